// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcode, funct, multiply/divide and ALU control definitions
package mips_ctrl_pkg;

    localparam int ALUCTRL_W_DEF = 8;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

endpackage

// File: rtl/pipe_controller_if.sv
// rtl/pipe_controller_if.sv - datapath/hazard-unit side signals of the pipeline controller
interface pipe_controller_if #(parameter int ALUCTRL_W = 8);
    logic [5:0]           opD;
    logic [5:0]           functD;
    logic                 equalD;
    logic                 pcsrcD, branchD, jumpD;
    logic                 stallE, stallM, stallW;
    logic                 flushE, flushM, flushW;
    logic                 memtoregE, alusrcE, regdstE, regwriteE, hilowriteE;
    logic [ALUCTRL_W-1:0] alucontrolE;
    logic [1:0]           mdopE;
    logic                 mdsignE, mdstartE, mdabortE, mdstallE;
    logic                 memtoregM, memwriteM, regwriteM, hilowriteM;
    logic                 memtoregW, regwriteW, hilowriteW;

    modport slave (
        input  opD, functD, equalD,
        input  stallE, stallM, stallW, flushE, flushM, flushW,
        output pcsrcD, branchD, jumpD,
        output memtoregE, alusrcE, regdstE, regwriteE, hilowriteE, alucontrolE,
        output mdopE, mdsignE, mdstartE, mdabortE, mdstallE,
        output memtoregM, memwriteM, regwriteM, hilowriteM,
        output memtoregW, regwriteW, hilowriteW
    );

    modport master (
        output opD, functD, equalD,
        output stallE, stallM, stallW, flushE, flushM, flushW,
        input  pcsrcD, branchD, jumpD,
        input  memtoregE, alusrcE, regdstE, regwriteE, hilowriteE, alucontrolE,
        input  mdopE, mdsignE, mdstartE, mdabortE, mdstallE,
        input  memtoregM, memwriteM, regwriteM, hilowriteM,
        input  memtoregW, regwriteW, hilowriteW
    );
endinterface

// File: rtl/aludec.sv
// rtl/aludec.sv - ALU control decoder from aluop and funct
module aludec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            2'b00: alucontrol = ALU_ADD;
            2'b01: alucontrol = ALU_SUB;
            default: begin
                case (funct)
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
        endcase
    end
endmodule

// File: rtl/flopenrc.sv
// rtl/flopenrc.sv - pipeline register with enable and synchronous clear (clear wins)
module flopenrc #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      q <= '0;
        else if (clr)  q <= '0;
        else if (en)   q <= d;
    end
endmodule

// File: rtl/maindec.sv
// rtl/maindec.sv - main opcode decoder with HI/LO and multiply/divide controls
module maindec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       memtoreg,
    output logic       memwrite,
    output logic       branch,
    output logic       alusrc,
    output logic       regdst,
    output logic       regwrite,
    output logic       jump,
    output logic       hilowrite,
    output logic [1:0] aluop,
    output md_op_t     mdop,
    output logic       mdsign
);
    always_comb begin
        memtoreg  = 1'b0;
        memwrite  = 1'b0;
        branch    = 1'b0;
        alusrc    = 1'b0;
        regdst    = 1'b0;
        regwrite  = 1'b0;
        jump      = 1'b0;
        hilowrite = 1'b0;
        aluop     = 2'b00;
        mdop      = MD_NONE;
        mdsign    = 1'b0;
        case (op)
            OP_RTYPE: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                aluop    = 2'b10;
                // multiply/divide results land in HI/LO, never in the register file
                case (funct)
                    FN_MULT:  begin regdst = 1'b0; regwrite = 1'b0; hilowrite = 1'b1; mdop = MD_MUL; mdsign = 1'b1; end
                    FN_MULTU: begin regdst = 1'b0; regwrite = 1'b0; hilowrite = 1'b1; mdop = MD_MUL; end
                    FN_DIV:   begin regdst = 1'b0; regwrite = 1'b0; hilowrite = 1'b1; mdop = MD_DIV; mdsign = 1'b1; end
                    FN_DIVU:  begin regdst = 1'b0; regwrite = 1'b0; hilowrite = 1'b1; mdop = MD_DIV; end
                    default:  ;
                endcase
            end
            OP_LW:   begin regwrite = 1'b1; alusrc = 1'b1; memtoreg = 1'b1; end
            OP_SW:   begin alusrc = 1'b1; memwrite = 1'b1; end
            OP_BEQ:  begin branch = 1'b1; aluop = 2'b01; end
            OP_ADDI: begin regwrite = 1'b1; alusrc = 1'b1; end
            OP_J:    jump = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/md_seq.sv
// rtl/md_seq.sv - multiply/divide sequencer holding the pipeline while the iterative unit runs
module md_seq
    import mips_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] md_op,
    input  logic       flush,
    input  logic       stall,
    output logic       md_start,
    output logic       md_abort,
    output logic       md_stall
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        md_start   = 1'b0;
        md_abort   = 1'b0;
        md_stall   = 1'b0;
        case (state)
            MD_IDLE: begin
                if (md_op != MD_NONE && !flush) begin
                    md_start   = 1'b1;
                    md_stall   = 1'b1;
                    cnt_next   = (md_op == MD_DIV) ? DIV_LOAD : MUL_LOAD;
                    state_next = MD_RUN;
                end
            end
            MD_RUN: begin
                md_stall = 1'b1;
                if (flush) begin
                    md_abort   = 1'b1;
                    state_next = MD_IDLE;
                end else if (cnt == CNT_ONE) begin
                    state_next = MD_DONE;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            MD_DONE: begin
                // leave only once the instruction actually moves out of E
                if (flush || !stall) state_next = MD_IDLE;
            end
            default: state_next = MD_IDLE;
        endcase
    end
endmodule

// File: rtl/pipe_controller.sv
// rtl/pipe_controller.sv - five-stage MIPS controller with E/M/W control pipeline and MD sequencer
module pipe_controller
    import mips_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = ALUCTRL_W_DEF,
    parameter int MUL_LAT   = 4,
    parameter int DIV_LAT   = 32
) (
    input  logic                clk,
    input  logic                rst,
    pipe_controller_if.slave    bus
);
    localparam int E_W = 9 + ALUCTRL_W;

    logic       memtoreg_d, memwrite_d, branch_d, alusrc_d, regdst_d, regwrite_d, hilowrite_d, mdsign_d;
    logic [1:0] aluop_d;
    md_op_t     mdop_d;
    logic [2:0] alu_ctrl_d;

    maindec u_maindec (
        .op(bus.opD), .funct(bus.functD),
        .memtoreg(memtoreg_d), .memwrite(memwrite_d), .branch(branch_d),
        .alusrc(alusrc_d), .regdst(regdst_d), .regwrite(regwrite_d),
        .jump(bus.jumpD), .hilowrite(hilowrite_d), .aluop(aluop_d),
        .mdop(mdop_d), .mdsign(mdsign_d)
    );

    aludec u_aludec (.funct(bus.functD), .aluop(aluop_d), .alucontrol(alu_ctrl_d));

    assign bus.branchD = branch_d;
    assign bus.pcsrcD  = branch_d & bus.equalD;

    logic [E_W-1:0]       ctrl_d, ctrl_e;
    logic                 memtoreg_e, memwrite_e, regwrite_e, hilowrite_e;
    logic [1:0]           mdop_e;
    logic [3:0]           ctrl_m;
    logic [2:0]           ctrl_w;

    assign ctrl_d = {memtoreg_d, memwrite_d, alusrc_d, regdst_d, regwrite_d, hilowrite_d,
                     mdsign_d, mdop_d, ALUCTRL_W'(alu_ctrl_d)};

    flopenrc #(.WIDTH(E_W)) u_reg_e (
        .clk(clk), .rst(rst), .en(!bus.stallE), .clr(bus.flushE), .d(ctrl_d), .q(ctrl_e)
    );

    assign {memtoreg_e, memwrite_e, bus.alusrcE, bus.regdstE, regwrite_e, hilowrite_e,
            bus.mdsignE, mdop_e, bus.alucontrolE} = ctrl_e;
    assign bus.memtoregE  = memtoreg_e;
    assign bus.regwriteE  = regwrite_e;
    assign bus.hilowriteE = hilowrite_e;
    assign bus.mdopE      = mdop_e;

    flopenrc #(.WIDTH(4)) u_reg_m (
        .clk(clk), .rst(rst), .en(!bus.stallM), .clr(bus.flushM),
        .d({memtoreg_e, memwrite_e, regwrite_e, hilowrite_e}), .q(ctrl_m)
    );
    assign {bus.memtoregM, bus.memwriteM, bus.regwriteM, bus.hilowriteM} = ctrl_m;

    flopenrc #(.WIDTH(3)) u_reg_w (
        .clk(clk), .rst(rst), .en(!bus.stallW), .clr(bus.flushW),
        .d({ctrl_m[3], ctrl_m[1], ctrl_m[0]}), .q(ctrl_w)
    );
    assign {bus.memtoregW, bus.regwriteW, bus.hilowriteW} = ctrl_w;

    md_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_seq (
        .clk(clk), .rst(rst), .md_op(mdop_e), .flush(bus.flushE), .stall(bus.stallE),
        .md_start(bus.mdstartE), .md_abort(bus.mdabortE), .md_stall(bus.mdstallE)
    );
endmodule

// File: doc/pipe_controller.md
# pipe_controller

Parametrised successor to the five-stage MIPS pipeline controller. It decodes op/funct in D and carries control bits through the E/M/W pipeline registers, with a per-stage stall and flush on each register. It adds HI/LO write control and a multi-cycle multiply/divide sequencer in E, which asks the hazard unit to hold the pipeline while the iterative MD unit runs. It sits between the datapath and the hazard unit in the top-level MIPS core.

## Interface
Parameters:
- ALUCTRL_W, 8: width of the ALU control field.
- MUL_LAT, 4: total stall cycles for MULT/MULTU. Must be ≥2.
- DIV_LAT, 32: total stall cycles for DIV/DIVU. Must be ≥2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- opD, functD  in  6 each  instruction fields in D.
- equalD  in  1  branch comparator result.
- pcsrcD, branchD, jumpD  out  1 each  D-stage decode.
- stallE, stallM, stallW  in  1 each  hold the corresponding stage register.
- flushE, flushM, flushW  in  1 each  load a bubble into the corresponding stage register.
- memtoregE, alusrcE, regdstE, regwriteE, hilowriteE  out  1 each  E-stage control.
- alucontrolE  out  ALUCTRL_W  E-stage ALU control.
- mdopE  out  2  MD operation in E: 00 none, 01 mult, 10 div.
- mdsignE  out  1  1 = signed (MULT/DIV).
- mdstartE  out  1  one-cycle start pulse to the MD unit.
- mdabortE  out  1  one-cycle abort pulse to the MD unit.
- mdstallE  out  1  stall request to the hazard unit.
- memtoregM, memwriteM, regwriteM, hilowriteM  out  1 each  M-stage control.
- memtoregW, regwriteW, hilowriteW  out  1 each  W-stage control.

## Operation
- D decode:
  - Combinational from opD/functD.
  - R-type funct 011000/011001/011010/011011 (MULT/MULTU/DIV/DIVU): regwrite=0, hilowrite=1, mdop and mdsign set as defined above.
  - pcsrcD = branchD & equalD.
- Stage registers E, M, W:
  - Each register takes all control bits of the previous stage.
  - flushX=1 loads all zeros, i.e. a bubble; flush has priority over stall.
  - Otherwise stallX=1 holds the register.
  - Otherwise the register loads the previous stage's bits.
- MD sequencer: states IDLE, RUN, DONE; counter cnt sized for max(MUL_LAT, DIV_LAT).
  - IDLE with mdopE≠0 and flushE=0:
    - mdstartE=1, mdstallE=1.
    - Load cnt = LAT-1, where LAT is MUL_LAT or DIV_LAT according to mdopE.
    - Next state RUN.
  - RUN:
    - mdstallE=1.
    - If cnt==1, next state DONE; else decrement cnt.
  - DONE:
    - mdstallE=0.
    - Return to IDLE on the first edge with stallE=0 (the instruction leaves E); stay in DONE while stallE=1.
  - flushE=1 in RUN or DONE: next state IDLE. mdabortE=1 that cycle if the state is RUN.
  - mdstallE = (IDLE & mdopE≠0 & !flushE) | RUN.
  - mdstartE and mdabortE are never both 1.
- Back-to-back MD instructions: the second one enters E as DONE exits to IDLE, and starts on the following cycle.

## Timing
- Reset: every register output is 0, FSM = IDLE, cnt = 0, all pulse outputs are 0.
- Control latency D→E→M→W is one cycle per stage when there is no stall or flush.
- An MD instruction asserts mdstallE for exactly LAT consecutive cycles and occupies E for LAT+1 cycles when stallE tracks mdstallE.
- An external stallE during IDLE/RUN does not pause the counter.
- Reset asserted mid-RUN aborts silently: no mdabortE pulse; outputs clear immediately (asynchronous).

## Structure
- Shared package `mips_ctrl_pkg`:
  - opcode/funct constants;
  - mdop encodings;
  - FSM state typedef;
  - ALUCTRL_W default.
- Reuse the existing maindec and aludec; extend maindec with hilowrite, mdop and mdsign outputs.
- One natural sub-module: `md_seq` (FSM + counter).
- Stage registers use the existing enable/clear flop with enable = !stall and clear = flush.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0, FSM IDLE; release rst → first ADD (functD 100000) shows regwriteE=1 one cycle later and regwriteW=1 three cycles after entering D.
- flushE=1 and stallE=1 in the same cycle on a LW → E holds a bubble (memtoregE=0, regwriteE=0).
- MULT with MUL_LAT=4 and stallE tied to mdstallE:
  - mdstartE pulses in cycle 0;
  - mdstallE is high in cycles 0–3 and low in cycle 4;
  - hilowriteM=1 in cycle 5.
- DIVU with DIV_LAT=32, flushE at cycle 10 → mdabortE=1 for one cycle, FSM IDLE next, no hilowriteM.
- Back-to-back DIV then MULTU → the second mdstartE comes 1 cycle after the first exits E; total stall = 32 + 4 cycles.
- BEQ with equalD=1 → pcsrcD=1; equalD=0 → pcsrcD=0; J → jumpD=1 and regwriteE=0.
